// File: rtl/tile_arb_pkg.sv
// Shared constants and helpers for the tile ROM arbiter.
// Holds the default widths, the transparent background colour,
// the lock burst cap and the requester-ID width function.
package tile_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_ROW_W  = 7;
  localparam int DEF_COL_W  = 4;
  localparam int DEF_DATA_W = 12;

  // Sprite background colour; pixels of this value are transparent.
  localparam logic [11:0] DEF_BG_COLOR = 12'h6DE;

  // A locked requester may stream at most this many consecutive grants.
  localparam int LOCK_CAP   = 64;
  localparam int LOCK_CNT_W = 6;

  // Requester index width; at least one bit even for two requesters.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_rom_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first eligible requester found scanning upward from ptr,
// wrapping N-1 -> 0, as a one-hot vector and as an index.
module rr_pick
  import tile_arb_pkg::*;
#(
  parameter int N   = DEF_N_REQ,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int             pos;
  logic [IDW-1:0] pos_idx;

  // Scan from the farthest offset down so the closest eligible bit to ptr wins.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IDW'(pos);
      if (elig[pos_idx]) begin
        onehot          = '0;
        onehot[pos_idx] = 1'b1;
        idx             = pos_idx;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read tile ROM among
// N_REQ sprite/platform requesters. Each accepted request comes back
// two edges later with its requester ID and a transparency flag.
// Optional macro TILE_ARB_LOCK_EN: a granted requester holding lock
// keeps the ROM for back-to-back grants, capped at LOCK_CAP in a row.
module tile_rom_arbiter
  import tile_arb_pkg::*;
#(
  parameter int               N_REQ    = DEF_N_REQ,
  parameter int               ROW_W    = DEF_ROW_W,
  parameter int               COL_W    = DEF_COL_W,
  parameter int               DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] BG_COLOR = DATA_W'(DEF_BG_COLOR),
  localparam int              ID_W     = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ROW_W-1:0] req_row,
  input  logic [N_REQ*COL_W-1:0] req_col,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       gnt,
  output logic [ROW_W-1:0]       rom_row,
  output logic [COL_W-1:0]       rom_col,
  input  logic [DATA_W-1:0]      rom_data,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_opaque,
  output logic                   busy
);

  logic [N_REQ-1:0] gnt_p1;
  logic [ROW_W-1:0] row_p1;
  logic [COL_W-1:0] col_p1;
  logic             vld_p1;
  logic [ID_W-1:0]  id_p1;
  logic             vld_p2;
  logic [ID_W-1:0]  id_p2;
  logic [ID_W-1:0]  rr_ptr;
  logic             busy_p1;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  logic [ROW_W-1:0] row_sel;
  logic [COL_W-1:0] col_sel;
  logic             hold;

  // Round-robin pointer advance with explicit wrap for any N_REQ.
  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    if (p == ID_W'(N_REQ - 1)) return '0;
    return p + ID_W'(1);
  endfunction

`ifdef TILE_ARB_LOCK_EN
  logic [LOCK_CNT_W-1:0] lock_cnt;

  // Current holder keeps the ROM while it locks, until the burst cap is hit.
  assign hold = (|(gnt_p1 & lock & req)) &&
                (lock_cnt != LOCK_CNT_W'(LOCK_CAP - 1));

  // Counts consecutive grants beyond the first one of a locked burst.
  always_ff @(posedge clk) begin
    if (reset) lock_cnt <= '0;
    else if (hold) lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
    else lock_cnt <= '0;
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  // A requester is masked in its own grant cycle unless it is holding a lock.
  always_comb begin
    elig = hold ? req : (req & ~gnt_p1);
  end

  rr_pick #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_pick (
    .elig   (elig),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Winner is the picker result, or the current holder during a locked burst.
  always_comb begin
    win_oh  = pick_oh;
    win_idx = pick_idx;
    win_any = pick_any;
    if (hold) begin
      win_oh  = gnt_p1;
      win_idx = id_p1;
      win_any = 1'b1;
    end
  end

  // Select the winner's packed row/column address.
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        row_sel = req_row[i*ROW_W +: ROW_W];
        col_sel = req_col[i*COL_W +: COL_W];
      end
    end
  end

  // Arbitration and response pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_p1  <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      vld_p2  <= 1'b0;
      id_p2   <= '0;
      rr_ptr  <= '0;
      busy_p1 <= 1'b0;
    end else begin
      // ---- p1: grant issued, address presented to the ROM ----
      gnt_p1  <= win_oh;
      vld_p1  <= win_any;
      busy_p1 <= |elig;
      if (win_any) begin
        row_p1 <= row_sel;
        col_p1 <= col_sel;
        id_p1  <= win_idx;
        if (!hold) rr_ptr <= ptr_inc(win_idx);
      end
      // ---- p2: ROM data valid, response tagged ----
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  assign gnt        = gnt_p1;
  assign rom_row    = row_p1;
  assign rom_col    = col_p1;
  assign busy       = busy_p1;
  assign rsp_valid  = vld_p2;
  assign rsp_id     = id_p2;
  assign rsp_data   = rom_data;
  assign rsp_opaque = vld_p2 && (rom_data != BG_COLOR);

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed bench for tile_rom_arbiter with a small synchronous ROM model.
// ROM content: 12'h6DE at (row 5, col 3), otherwise {1'b0, row, col}.
module tb_tile_rom_arbiter;

  localparam int N     = 4;
  localparam int ROW_W = 7;
  localparam int COL_W = 4;
  localparam int DW    = 12;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*ROW_W-1:0] req_row;
  logic [N*COL_W-1:0] req_col;
  logic [N-1:0]      lock;
  logic [N-1:0]      gnt;
  logic [ROW_W-1:0]  rom_row;
  logic [COL_W-1:0]  rom_col;
  logic [DW-1:0]     rom_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_opaque;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;

  tile_rom_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_row    (req_row),
    .req_col    (req_col),
    .lock       (lock),
    .gnt        (gnt),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_opaque (rsp_opaque),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    if (r == 7'd5 && c == 4'd3) return 12'h6DE;
    return {1'b0, r, c};
  endfunction

  always_ff @(posedge clk) rom_data <= rom_val(rom_row, rom_col);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    req_row[i*ROW_W +: ROW_W] = r;
    req_col[i*COL_W +: COL_W] = c;
  endtask

  initial begin
    int w;
    int p;
    req = '0; lock = '0; req_row = '0; req_col = '0; reset = 1'b1;
    step(); step();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_row",   32'(rom_row), 32'h0);
    chk("rst_col",   32'(rom_col), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id",    32'(rsp_id), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);

    // Single requester 0, toggling grant, transparent then opaque pixel
    reset = 1'b0; set_addr(0, 7'd5, 4'd3); req = 4'b0001;
    step();
    chk("a_gnt",   32'(gnt), 32'h1);
    chk("a_row",   32'(rom_row), 32'd5);
    chk("a_col",   32'(rom_col), 32'd3);
    chk("a_busy",  32'(busy), 32'h1);
    chk("a_vld0",  32'(rsp_valid), 32'h0);
    step();
    chk("a_vld1",  32'(rsp_valid), 32'h1);
    chk("a_id",    32'(rsp_id), 32'h0);
    chk("a_data",  32'(rsp_data), 32'h6DE);
    chk("a_opq0",  32'(rsp_opaque), 32'h0);
    chk("a_gnt0",  32'(gnt), 32'h0);
    chk("a_busy0", 32'(busy), 32'h0);
    step();
    chk("a_gnt2",  32'(gnt), 32'h1);
    chk("a_vld2",  32'(rsp_valid), 32'h0);
    step();
    chk("a_gnt3",  32'(gnt), 32'h0);
    chk("a_vld3",  32'(rsp_valid), 32'h1);
    set_addr(0, 7'd6, 4'd1);
    step();
    chk("a_gnt4",  32'(gnt), 32'h1);
    chk("a_row4",  32'(rom_row), 32'd6);
    step();
    chk("a_vld5",  32'(rsp_valid), 32'h1);
    chk("a_data5", 32'(rsp_data), 32'h061);
    chk("a_opq5",  32'(rsp_opaque), 32'h1);
    req = 4'b0000;
    step();
    chk("a_idle_gnt", 32'(gnt), 32'h0);
    chk("a_idle_vld", 32'(rsp_valid), 32'h0);

    // All four requesting: one grant per cycle in rotation
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_addr(i, ROW_W'(10 + i), COL_W'(i));
`ifdef TILE_ARB_LOCK_EN
    lock = 4'b0000;
`else
    lock = 4'b1111;
`endif
    req = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      step();
      w = (k - 1) % 4;
      chk("b_gnt", 32'(gnt), 32'(1) << w);
      chk("b_row", 32'(rom_row), 32'(10 + w));
      if (k >= 2) begin
        p = (k - 2) % 4;
        chk("b_vld",  32'(rsp_valid), 32'h1);
        chk("b_id",   32'(rsp_id), 32'(p));
        chk("b_data", 32'(rsp_data), 32'(rom_val(ROW_W'(10 + p), COL_W'(p))));
      end
    end
    req = 4'b0000; lock = 4'b0000;

    // Pointer at 2 with requesters 0 and 1: wrap to 0, then 1
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0010;
    step();
    chk("c_gnt1", 32'(gnt), 32'h2);
    req = 4'b0011;
    step();
    chk("c_wrap0", 32'(gnt), 32'h1);
    step();
    chk("c_then1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();

    // Reset between grant and response drops the response
    reset = 1'b1; step(); reset = 1'b0;
    set_addr(0, 7'd5, 4'd3); req = 4'b0001;
    step();
    chk("d_gnt", 32'(gnt), 32'h1);
    reset = 1'b1;
    step();
    chk("d_vld_rst", 32'(rsp_valid), 32'h0);
    chk("d_gnt_rst", 32'(gnt), 32'h0);
    chk("d_busy_rst", 32'(busy), 32'h0);
    reset = 1'b0; set_addr(3, 7'd20, 4'd7); req = 4'b1001;
    step();
    chk("d_gnt0",   32'(gnt), 32'h1);
    chk("d_vld_after", 32'(rsp_valid), 32'h0);
    step();
    chk("d_gnt3",   32'(gnt), 32'h8);
    chk("d_row3",   32'(rom_row), 32'd20);
    chk("d_vld",    32'(rsp_valid), 32'h1);
    chk("d_id",     32'(rsp_id), 32'h0);
    req = 4'b0000;

`ifdef TILE_ARB_LOCK_EN
    // Locked streaming: requester 1 holds for 64 grants, then 0 once
    reset = 1'b1; step(); reset = 1'b0;
    set_addr(0, 7'd1, 4'd1); set_addr(1, 7'd2, 4'd2);
    req = 4'b0011; lock = 4'b0010;
    step();
    chk("e_first0", 32'(gnt), 32'h1);
    for (int k = 0; k < 64; k++) begin
      step();
      chk("e_hold1", 32'(gnt), 32'h2);
    end
    chk("e_hold_id", 32'(rsp_id), 32'h1);
    step();
    chk("e_release0", 32'(gnt), 32'h1);
    req = 4'b0000; lock = 4'b0000;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_rom_arbiter.md
Name: tile_rom_arbiter

Overview:
- Shares one synchronous-read tile ROM (row/col addressed, 12-bit RGB out) among up to N_REQ pixel-sprite requesters (platforms, walls, enemies, player).
- Round-robin arbitration; each accepted request is returned with requester ID and an opaque flag (data != BG_COLOR).
- Sits between the sprite/platform renderers and the tile ROM, replacing per-renderer ROM instances.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ROW_W, 7, ROM row address width
- COL_W, 4, ROM column address width
- DATA_W, 12, ROM data width (4:4:4 RGB)
- BG_COLOR, 12'h6DE, sprite background (transparent) colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester read request
- req_row  in  N_REQ*ROW_W  packed row address, requester i at [i*ROW_W +: ROW_W]
- req_col  in  N_REQ*COL_W  packed column address, same packing
- lock  in  N_REQ  burst-hold request (used only with TILE_ARB_LOCK_EN)
- gnt  out  N_REQ  one-hot, registered, one-cycle accept pulse
- rom_row  out  ROW_W  registered ROM row address
- rom_col  out  COL_W  registered ROM column address
- rom_data  in  DATA_W  ROM output, valid one cycle after address
- rsp_valid  out  1  response valid, aligned with rom_data
- rsp_id  out  $clog2(N_REQ)  requester index of current response
- rsp_data  out  DATA_W  combinational pass-through of rom_data
- rsp_opaque  out  1  rsp_valid && (rom_data != BG_COLOR)
- busy  out  1  registered; 1 when any unmasked req was pending at last edge

Behaviour:
- Reset (sync): gnt=0, rom_row=0, rom_col=0, rsp_valid=0, rsp_id=0, busy=0, rr_ptr=0. Reset mid-transaction drops the in-flight response; no rsp_valid in the cycle after reset.
- Eligible set per cycle: elig = req & ~gnt (a requester holding req in its own grant cycle is masked for that cycle). Max one grant per requester per two cycles.
- Pick: first set bit of elig scanning from rr_ptr upward, wrapping N_REQ-1 -> 0.
- Edge E0 with winner w: gnt <= onehot(w); rom_row/rom_col <= w's address; rr_ptr <= (w+1) mod N_REQ; pipeline v1 <= 1, id1 <= w.
- No winner at E0: gnt <= 0; rom_row/rom_col hold; v1 <= 0; rr_ptr holds.
- Edge E1: rsp_valid <= v1, rsp_id <= id1. ROM latches address at E1, so rom_data, rsp_data and rsp_opaque are valid with rsp_valid.
- Latency: req seen before E0 -> gnt high in cycle after E0 -> rsp_valid in cycle after E1. Throughput: one access per cycle when two or more requesters are active.
- Requester contract: hold req, req_row and req_col stable until gnt seen. Addresses change only in the gnt cycle or later. Dropping req before gnt withdraws the request, with no side effects.
- Simultaneous requests: exactly one gnt bit set. The others wait and are served in rotating order. No requester waits more than N_REQ-1 grants.
- busy <= |elig at every edge.
- rr_ptr arithmetic: $clog2(N_REQ)-bit with explicit wrap (non-power-of-2 N_REQ supported).

Optional Feature:
- Macro TILE_ARB_LOCK_EN.
- Defined: if current gnt holder w has lock[w]=1 and req[w]=1, w is not masked. w wins unconditionally and rr_ptr holds, giving back-to-back streaming (one pixel/cycle, e.g. a whole scanline span). When lock[w] drops, normal rotation resumes from the held rr_ptr. Lock is capped at 64 consecutive grants by a 6-bit counter; the 64th forces release to rotation for one arbitration.
- Undefined: lock port present but ignored; masking rule always applies.

Decomposition:
- Package tile_arb_pkg: BG_COLOR constant, default widths, ID width function, lock cap constant (64).
- Sub-module rr_pick: combinational round-robin picker (elig, rr_ptr -> onehot, index, any).
- Arbiter top holds all registers.

Test Plan:
- Reset, then req=4'b0001, row=5, col=3 -> gnt=0001 one cycle after; rom_row=5, rom_col=3; rsp_valid=1, rsp_id=0 next cycle; rsp_opaque=0 when rom_data=12'h6DE.
- req=4'b1111 held continuously -> grants 0,1,2,3,0,... one per cycle; rsp_id follows same sequence two cycles behind.
- Single requester held high -> gnt toggles 1,0,1,0; rsp_valid every other cycle.
- rr_ptr=2 and req=4'b0011 -> grant to 0 then 1; wrap verified.
- Reset asserted in cycle between gnt and rsp_valid -> rsp_valid stays 0 and gnt=0 after reset; next req from 0 granted first.
- TILE_ARB_LOCK_EN, req=4'b0011, lock[1]=1 after first grant to 1 -> requester 1 granted 64 consecutive cycles, then requester 0 granted once.
